// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: default geometry and Sub-mode encoding shared with the ALU decoder
package pipelined_adder_pkg;
    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;
    typedef enum logic {ADD = 1'b0, SUB = 1'b1} sub_mode_e;
endpackage

// File: rtl/pipelined_adder_chunk.sv
// adder_chunk: combinational W-bit ripple of full-adder cells, exposing the carry into the top bit
module adder_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);
    logic [W:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout  = c[W];
    assign c_msb = c[W-1];
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep chunked adder/subtractor with valid/ready flow control and C/V/Z flags
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow,
    output logic             Zero
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

    if (WIDTH % STAGES != 0) begin : g_chk
        $fatal(1, "pipelined_adder: WIDTH must be divisible by STAGES");
    end

    logic adv, acc, cin0;
    logic [WIDTH-1:0] b_eff;
    logic [STAGES-1:0] v_q, v_d, c_q, c_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic ovf_q, ovf_d, z_q, z_d;

    // The whole pipe moves as one; a held output freezes every stage behind it
    assign adv   = !v_q[STAGES-1] || out_ready;
    assign acc   = in_valid && adv;
    assign b_eff = (Sub == SUB) ? ~B : B;
    assign cin0  = (Sub == SUB) ? 1'b1 : Cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic vi, ci, co, cm;
        logic [WIDTH-1:0] ai, bi, si;
        logic [CHUNK-1:0] cs;
        if (k == 0) begin : g_head
            assign {vi, ci, ai, bi, si} = {acc, cin0, A, b_eff, {WIDTH{1'b0}}};
        end else begin : g_tail
            assign {vi, ci, ai, bi, si} = {v_q[k-1], c_q[k-1], a_q[k-1], b_q[k-1], s_q[k-1]};
        end
        adder_chunk #(.W(CHUNK)) u_chunk (
            .a    (ai[k*CHUNK +: CHUNK]),
            .b    (bi[k*CHUNK +: CHUNK]),
            .cin  (ci),
            .sum  (cs),
            .cout (co),
            .c_msb(cm)
        );
        assign v_d[k] = vi;
        assign c_d[k] = co;
        assign a_d[k] = ai;
        assign b_d[k] = bi;
        assign s_d[k] = (si & ~(CMASK << (k * CHUNK))) | (WIDTH'(cs) << (k * CHUNK));
        if (k == STAGES - 1) begin : g_flags
            assign ovf_d = cm ^ co;
            assign z_d   = s_d[k] == '0;
        end
    end

    // Stage registers: reset discards in-flight beats, stall holds everything including flags
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            ovf_q <= 1'b0;
            z_q   <= 1'b0;
        end else if (adv) begin
            v_q   <= v_d;
            c_q   <= c_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            ovf_q <= ovf_d;
            z_q   <= z_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = v_q[STAGES-1];
    assign Sum       = s_q[STAGES-1];
    assign Carry     = c_q[STAGES-1];
    assign Overflow  = ovf_q;
    assign Zero      = z_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: random and directed stimulus into STAGES=4/1/16 instances, checked against an arithmetic scoreboard
module tb_pipelined_adder;
    localparam int ST [3] = '{4, 1, 16};

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
        logic        z;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1, in_valid = 1'b0, Cin = 1'b0, Sub = 1'b0, out_ready = 1'b1;
    logic [15:0] A = '0, B = '0;
    logic [2:0] ir, ov, cy, of, zr;
    logic [15:0] sm [3];

    int checks = 0, errors = 0, cyc = 0;
    bit started = 0, rst_prev = 0;
    res_t q [3][$];
    int dq [3][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pipelined_adder #(.WIDTH(16), .STAGES(ST[g])) dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (ir[g]),
            .A        (A),
            .B        (B),
            .Cin      (Cin),
            .Sub      (Sub),
            .out_valid(ov[g]),
            .out_ready(out_ready),
            .Sum      (sm[g]),
            .Carry    (cy[g]),
            .Overflow (of[g]),
            .Zero     (zr[g])
        );
    end

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        res_t r;
        logic [15:0] bb;
        int ci, u, s;
        bb  = sub ? ~b : b;
        ci  = sub ? 1 : int'(cin);
        u   = int'(a) + int'(bb) + ci;
        s   = int'($signed(a)) + int'($signed(bb)) + ci;
        r.s = u[15:0];
        r.c = u > 65535;
        r.o = s > 32767 || s < -32768;
        r.z = u[15:0] == 16'h0000;
        return r;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s stages=%0d cycle=%0d: got %0h expected %0h", name, d < 0 ? 0 : ST[d], cyc, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sb, input logic ordy);
        @(negedge clk);
        #1;
        rst = r; in_valid = v; A = a; B = b; Cin = ci; Sub = sb; out_ready = ordy;
    endtask

    function automatic logic [15:0] pick();
        logic [15:0] corner [5] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001};
        return ($urandom_range(3) == 0) ? corner[$urandom_range(4)] : 16'($urandom);
    endfunction

    // Compare process: sampled shortly before each rising edge, after the driver has settled inputs
    always begin
        @(negedge clk);
        #3;
        cyc++;
        if (rst) begin
            started  = 1;
            rst_prev = 1;
            for (int d = 0; d < 3; d++) begin
                q[d].delete();
                dq[d].delete();
            end
        end else if (started) begin
            for (int d = 0; d < 3; d++) begin
                bit ev;
                ev = q[d].size() > 0 && dq[d][0] == cyc;
                if (rst_prev)
                    chk("reset_outputs", d, {ov[d], sm[d], cy[d], of[d], zr[d]}, 32'h0);
                chk("out_valid", d, 32'(ov[d]), 32'(ev));
                chk("in_ready", d, 32'(ir[d]), 32'(!ev || out_ready));
                if (ev && ov[d]) begin
                    chk("sum", d, 32'(sm[d]), 32'(q[d][0].s));
                    chk("carry", d, 32'(cy[d]), 32'(q[d][0].c));
                    chk("overflow", d, 32'(of[d]), 32'(q[d][0].o));
                    chk("zero", d, 32'(zr[d]), 32'(q[d][0].z));
                end
                if (ev && out_ready) begin
                    void'(q[d].pop_front());
                    void'(dq[d].pop_front());
                end else if (ev) begin
                    foreach (dq[d][i]) dq[d][i] = dq[d][i] + 1;
                end
                if (in_valid && (!ev || out_ready)) begin
                    q[d].push_back(model(A, B, Cin, Sub));
                    dq[d].push_back(cyc + ST[d]);
                end
            end
            rst_prev = 0;
        end
    end

    initial begin
        chk("pin_zero", -1, 32'(model(16'h0000, 16'h0000, 1'b0, 1'b0)), 32'({16'h0000, 3'b001}));
        chk("pin_cin", -1, 32'(model(16'h0001, 16'h0001, 1'b1, 1'b0)), 32'({16'h0003, 3'b000}));
        chk("pin_wrap", -1, 32'(model(16'hFFFF, 16'h0001, 1'b0, 1'b0)), 32'({16'h0000, 3'b101}));
        chk("pin_ovf", -1, 32'(model(16'h7FFF, 16'h0001, 1'b0, 1'b0)), 32'({16'h8000, 3'b010}));
        chk("pin_sub", -1, 32'(model(16'h0005, 16'h0007, 1'b0, 1'b1)), 32'({16'hFFFE, 3'b000}));
        chk("pin_sub_cin", -1, 32'(model(16'h0005, 16'h0007, 1'b1, 1'b1)), 32'({16'hFFFE, 3'b000}));
        chk("pin_sub_ovf", -1, 32'(model(16'h8000, 16'h0001, 1'b0, 1'b1)), 32'({16'h7FFF, 3'b110}));
        chk("pin_sub_ovf_cin", -1, 32'(model(16'h8000, 16'h0001, 1'b1, 1'b1)), 32'({16'h7FFF, 3'b110}));
        repeat (3) drive(1, 0, 0, 0, 0, 0, 1);
        drive(0, 1, 16'h0000, 16'h0000, 0, 0, 1);
        repeat (6) drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 1, 16'h0001, 16'h0001, 1, 0, 1);
        drive(0, 1, 16'hFFFF, 16'h0001, 0, 0, 1);
        drive(0, 1, 16'h7FFF, 16'h0001, 0, 0, 1);
        drive(0, 1, 16'h0005, 16'h0007, 0, 1, 1);
        drive(0, 1, 16'h8000, 16'h0001, 0, 1, 1);
        drive(0, 1, 16'h0005, 16'h0007, 1, 1, 1);
        drive(0, 1, 16'h8000, 16'h0001, 1, 1, 1);
        repeat (20) drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++)
            drive(0, 1, pick(), pick(), 1'($urandom), 1'($urandom), !(i >= 4 && i < 7));
        repeat (20) drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(0, 1, pick(), pick(), 0, 0, 1);
        drive(1, 1, 16'h1234, 16'h4321, 0, 0, 1);
        drive(0, 1, 16'h1234, 16'h4321, 1, 0, 1);
        repeat (20) drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(255) == 0, $urandom_range(3) != 0, pick(), pick(),
                  1'($urandom), 1'($urandom), $urandom_range(9) < 7);
        begin
            int n = 0;
            drive(0, 0, 0, 0, 0, 0, 1);
            while (q[0].size() + q[1].size() + q[2].size() > 0 && n < 100) begin
                drive(0, 0, 0, 0, 0, 0, 1);
                n++;
            end
            chk("drain", -1, 32'(q[0].size() + q[1].size() + q[2].size()), 32'h0);
        end
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
